// File: rtl/vbk_pkg.sv
// rtl/vbk_pkg.sv - shared states and defaults for the vertical-blank interrupt / watchdog block
package vbk_pkg;

    typedef enum logic [1:0] {
        POR  = 2'd0,
        RUN  = 2'd1,
        BITE = 2'd2
    } state_t;

    localparam int WDOG_LIMIT_DEF  = 8;
    localparam int RES_STRETCH_DEF = 16;

endpackage

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - registered rising-edge detector producing a one-cycle pulse per low->high transition
module edge_rise #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    // Feeds only registered logic in the parent, so the event lands on the sampling edge.
    assign rise = d & ~d_q;

endmodule

// File: rtl/vbk_irq_watchdog.sv
// rtl/vbk_irq_watchdog.sv - per-frame vblank interrupt plus POR stretch and frame-counting watchdog reset
module vbk_irq_watchdog
    import vbk_pkg::*;
#(
    parameter int WDOG_LIMIT  = WDOG_LIMIT_DEF,
    parameter int RES_STRETCH = RES_STRETCH_DEF
) (
    input  logic MCKR,
    input  logic RESET,
    input  logic VBLANK,
    input  logic VBKACK_b,
    input  logic WDOG_b,
    input  logic WDOG_DIS,
    output logic VBKINIT_b,
    output logic SYSRES_b,
    output logic WDOG_FIRED
);

    localparam int WW = $clog2(WDOG_LIMIT + 1);
    localparam int SW = $clog2(RES_STRETCH);

    state_t         state, state_n;
    logic [SW-1:0]  stretch_cnt, stretch_n;
    logic [WW-1:0]  wd_cnt, wd_n;
    logic           vbkinit_n, sysres_n, fired_n;
    logic           frame_tick, ack_evt, kick_evt;

    edge_rise #(.RESET_VAL(1'b0)) u_vblank_edge (
        .clk  (MCKR),
        .rst  (RESET),
        .d    (VBLANK),
        .rise (frame_tick)
    );

    edge_rise #(.RESET_VAL(1'b1)) u_ack_edge (
        .clk  (MCKR),
        .rst  (RESET),
        .d    (VBKACK_b),
        .rise (ack_evt)
    );

    edge_rise #(.RESET_VAL(1'b1)) u_kick_edge (
        .clk  (MCKR),
        .rst  (RESET),
        .d    (WDOG_b),
        .rise (kick_evt)
    );

    always_ff @(posedge MCKR) begin
        if (RESET) begin
            state       <= POR;
            stretch_cnt <= '0;
            wd_cnt      <= '0;
            VBKINIT_b   <= 1'b1;
            SYSRES_b    <= 1'b0;
            WDOG_FIRED  <= 1'b0;
        end else begin
            state       <= state_n;
            stretch_cnt <= stretch_n;
            wd_cnt      <= wd_n;
            VBKINIT_b   <= vbkinit_n;
            SYSRES_b    <= sysres_n;
            WDOG_FIRED  <= fired_n;
        end
    end

    always_comb begin
        state_n   = state;
        stretch_n = stretch_cnt;
        wd_n      = wd_cnt;
        vbkinit_n = VBKINIT_b;
        fired_n   = WDOG_FIRED;

        case (state)
            RUN: begin
                if (frame_tick) begin
                    vbkinit_n = 1'b0;
                end else if (ack_evt) begin
                    vbkinit_n = 1'b1;
                end

                // Kick beats a coincident frame tick; disable pins the counter at zero.
                if (WDOG_DIS || kick_evt) begin
                    wd_n = '0;
                end else if (frame_tick) begin
                    if (wd_cnt == WW'(WDOG_LIMIT - 1)) begin
                        state_n   = BITE;
                        stretch_n = '0;
                        wd_n      = '0;
                        vbkinit_n = 1'b1;
                        fired_n   = 1'b1;
                    end else if (wd_cnt != WW'(WDOG_LIMIT)) begin
                        wd_n = wd_cnt + 1'b1;
                    end
                end
            end

            default: begin
                // POR and BITE share the stretch: CPU held in reset, events ignored.
                vbkinit_n = 1'b1;
                wd_n      = '0;
                if (stretch_cnt == SW'(RES_STRETCH - 1)) begin
                    state_n   = RUN;
                    stretch_n = '0;
                end else begin
                    stretch_n = stretch_cnt + 1'b1;
                end
            end
        endcase

        sysres_n = (state_n == RUN);
    end

endmodule

// File: tb/tb_vbk_irq_watchdog.sv
// tb/tb_vbk_irq_watchdog.sv - self-checking bench for vbk_irq_watchdog
module tb_vbk_irq_watchdog;

    localparam int L  = 8;
    localparam int RS = 16;

    logic MCKR = 1'b0;
    logic RESET, VBLANK, VBKACK_b, WDOG_b, WDOG_DIS;
    logic VBKINIT_b, SYSRES_b, WDOG_FIRED;

    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;
    bit  watch = 1'b0;
    int  low_seen = 0;

    vbk_irq_watchdog #(.WDOG_LIMIT(L), .RES_STRETCH(RS)) dut (
        .MCKR       (MCKR),
        .RESET      (RESET),
        .VBLANK     (VBLANK),
        .VBKACK_b   (VBKACK_b),
        .WDOG_b     (WDOG_b),
        .WDOG_DIS   (WDOG_DIS),
        .VBKINIT_b  (VBKINIT_b),
        .SYSRES_b   (SYSRES_b),
        .WDOG_FIRED (WDOG_FIRED)
    );

    always #5 MCKR = ~MCKR;

    typedef struct {
        int hold;
        bit irq;
        int frames;
        bit fired;
        bit pv, pa, pk;
    } mstate_t;

    mstate_t m;

    // hold = cycles of CPU reset still owed; frames = frames since last kick.
    function automatic mstate_t step(mstate_t s, bit rst, bit v, bit a, bit k, bit dis);
        mstate_t n = s;
        bit tick = v && !s.pv;
        bit ack  = a && !s.pa;
        bit kick = k && !s.pk;
        if (rst) begin
            n.hold = RS; n.irq = 0; n.frames = 0; n.fired = 0;
            n.pv = 0; n.pa = 1; n.pk = 1;
            return n;
        end
        if (s.hold > 0) begin
            n.hold = s.hold - 1;
            n.irq = 0;
            n.frames = 0;
        end else begin
            if (tick) n.irq = 1;
            else if (ack) n.irq = 0;
            if (dis || kick) n.frames = 0;
            else if (tick) n.frames = s.frames + 1;
            if (n.frames >= L) begin
                n.hold = RS; n.fired = 1; n.irq = 0; n.frames = 0;
            end
        end
        n.pv = v; n.pa = a; n.pk = k;
        return n;
    endfunction

    always @(posedge MCKR) m <= step(m, RESET, VBLANK, VBKACK_b, WDOG_b, WDOG_DIS);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge MCKR) begin
        if (chk_en) begin
            chk("model_sysres", 32'(SYSRES_b), 32'(m.hold == 0));
            chk("model_vbkinit", 32'(VBKINIT_b), 32'(!m.irq));
            chk("model_fired", 32'(WDOG_FIRED), 32'(m.fired));
        end
        if (watch && !SYSRES_b) low_seen++;
    end

    task automatic cyc();
        @(posedge MCKR);
        #2;
    endtask

    task automatic frame();
        VBLANK = 1'b1;
        cyc(); cyc();
        VBLANK = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic kick();
        WDOG_b = 1'b0;
        cyc(); cyc();
        WDOG_b = 1'b1;
        cyc();
    endtask

    task automatic count_sysres_low(output int n);
        n = 0;
        while (SYSRES_b == 1'b0 && n < 40) begin
            n++;
            cyc();
        end
    endtask

    int n;
    int toggles;

    initial begin
        RESET = 1'b1; VBLANK = 1'b0; VBKACK_b = 1'b1; WDOG_b = 1'b1; WDOG_DIS = 1'b0;
        cyc();
        chk_en = 1'b1;
        chk("reset_sysres", 32'(SYSRES_b), 32'd0);
        chk("reset_vbkinit", 32'(VBKINIT_b), 32'd1);
        chk("reset_fired", 32'(WDOG_FIRED), 32'd0);
        cyc(); cyc();
        RESET = 1'b0;
        count_sysres_low(n);
        chk("por_stretch_len", 32'(n), 32'd16);

        // Interrupt request and acknowledge
        VBLANK = 1'b1;
        cyc();
        chk("irq_latency", 32'(VBKINIT_b), 32'd0);
        cyc(); cyc();
        VBLANK = 1'b0;
        VBKACK_b = 1'b0;
        repeat (4) cyc();
        chk("irq_held_during_ack", 32'(VBKINIT_b), 32'd0);
        VBKACK_b = 1'b1;
        cyc();
        chk("irq_acked", 32'(VBKINIT_b), 32'd1);
        cyc();

        // Frame tick coincident with an ack release: set wins
        VBLANK = 1'b1;
        cyc(); cyc();
        VBLANK = 1'b0;
        VBKACK_b = 1'b0;
        cyc(); cyc();
        VBKACK_b = 1'b1;
        VBLANK = 1'b1;
        cyc();
        chk("set_beats_ack", 32'(VBKINIT_b), 32'd0);
        VBLANK = 1'b0;
        cyc();
        kick();

        // Eight unkicked frames bite
        repeat (L - 1) frame();
        chk("no_bite_at_7", 32'(SYSRES_b), 32'd1);
        VBLANK = 1'b1;
        cyc();
        chk("bite_sysres", 32'(SYSRES_b), 32'd0);
        chk("bite_fired", 32'(WDOG_FIRED), 32'd1);
        chk("bite_vbkinit", 32'(VBKINIT_b), 32'd1);
        count_sysres_low(n);
        chk("bite_stretch_len", 32'(n), 32'd16);
        VBLANK = 1'b0;
        cyc();

        // Kick every seventh frame keeps the CPU running
        low_seen = 0;
        watch = 1'b1;
        for (int i = 0; i < 50; i++) begin
            frame();
            if (i % 7 == 6) kick();
        end
        watch = 1'b0;
        chk("kick7_no_reset", 32'(low_seen), 32'd0);
        chk("fired_sticky", 32'(WDOG_FIRED), 32'd1);
        kick();

        // Kick coincident with the eighth tick
        repeat (L - 1) frame();
        WDOG_b = 1'b0;
        cyc(); cyc();
        WDOG_b = 1'b1;
        VBLANK = 1'b1;
        cyc();
        chk("kick_beats_tick", 32'(SYSRES_b), 32'd1);
        cyc();
        VBLANK = 1'b0;
        repeat (4) cyc();
        repeat (L - 1) frame();
        chk("counter_was_cleared", 32'(SYSRES_b), 32'd1);
        kick();

        // Watchdog disabled for 20 frames; interrupts continue
        WDOG_DIS = 1'b1;
        toggles = 0;
        for (int i = 0; i < 20; i++) begin
            VBLANK = 1'b1;
            cyc();
            if (VBKINIT_b == 1'b0) toggles++;
            cyc();
            VBLANK = 1'b0;
            VBKACK_b = 1'b0;
            cyc();
            VBKACK_b = 1'b1;
            cyc();
            if (VBKINIT_b == 1'b1) toggles++;
            cyc();
        end
        chk("dis_irq_toggles", 32'(toggles), 32'd40);
        chk("dis_no_bite", 32'(SYSRES_b), 32'd1);
        WDOG_DIS = 1'b0;
        cyc();

        // Board reset in the middle of a bite
        repeat (L - 1) frame();
        VBLANK = 1'b1;
        cyc();
        chk("bite2_sysres", 32'(SYSRES_b), 32'd0);
        VBLANK = 1'b0;
        repeat (4) cyc();
        RESET = 1'b1;
        cyc();
        chk("midbite_reset_fired", 32'(WDOG_FIRED), 32'd0);
        chk("midbite_reset_sysres", 32'(SYSRES_b), 32'd0);
        cyc();
        RESET = 1'b0;
        count_sysres_low(n);
        chk("midbite_por_len", 32'(n), 32'd16);
        chk("midbite_fired_after", 32'(WDOG_FIRED), 32'd0);
        repeat (3) cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
